hazard_scoreboard: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It is the controlling end of the stage-register interface: it drives the stall and flush inputs of the IF/ID and ID/EX registers and the EX-stage forwarding muxes. It keeps its own 3-entry scoreboard, one entry per stage (EX, MEM, WB), so hazard decisions need no taps on downstream pipeline registers.

---
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 tb/tb_hazard_scoreboard.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use stall, branch flush and EX forwarding control.
// Define HAZARD_FORWARD_EN for forwarding; otherwise every RAW dependency stalls.
module hazard_scoreboard #(
  parameter int XLEN_REGS = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(XLEN_REGS)-1:0] rs1_id,
  input  logic [$clog2(XLEN_REGS)-1:0] rs2_id,
  input  logic [$clog2(XLEN_REGS)-1:0] rd_id,
  input  logic                         reg_write_id,
  input  logic [1:0]                   result_src_id,
  input  logic                         pc_src_ex,
  output logic                         stall_if,
  output logic                         stall_id,
  output logic                         flush_id,
  output logic                         flush_ex,
  output logic [1:0]                   forward_a_ex,
  output logic [1:0]                   forward_b_ex
);

  localparam int RW = $clog2(XLEN_REGS);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          is_load;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
  } ex_ent_t;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
  } wr_ent_t;

  ex_ent_t ex_q;
  ex_ent_t ex_d;
  wr_ent_t mem_q;
  wr_ent_t wb_q;

  logic hit_ex;
  logic hit_mem;
  logic raw_stall;

  // x0 is never a real producer, so a zero source never matches
  function automatic logic hit(
    input logic          v,
    input logic [RW-1:0] rd,
    input logic [RW-1:0] rs
  );
    return v && (rs != '0) && (rd == rs);
  endfunction

  always_comb begin
    ex_d         = '0;
    ex_d.valid   = reg_write_id & (rd_id != '0);
    ex_d.rd      = rd_id;
    ex_d.is_load = (result_src_id == 2'b01);
    ex_d.rs1     = rs1_id;
    ex_d.rs2     = rs2_id;
  end

  assign hit_ex  = hit(ex_q.valid, ex_q.rd, rs1_id)
                 | hit(ex_q.valid, ex_q.rd, rs2_id);
  assign hit_mem = hit(mem_q.valid, mem_q.rd, rs1_id)
                 | hit(mem_q.valid, mem_q.rd, rs2_id);

`ifdef HAZARD_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] rs);
    if (hit(mem_q.valid, mem_q.rd, rs))
      return 2'b10;
    else if (hit(wb_q.valid, wb_q.rd, rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  logic unused_mem;
  assign unused_mem   = hit_mem;
  assign raw_stall    = ex_q.is_load & hit_ex;
  assign forward_a_ex = reset ? fwd_sel(ex_q.rs1) : 2'b00;
  assign forward_b_ex = reset ? fwd_sel(ex_q.rs2) : 2'b00;
`else
  logic unused_fwd;
  assign unused_fwd   = ^{ex_q.is_load, ex_q.rs1, ex_q.rs2, wb_q};
  assign raw_stall    = hit_ex | hit_mem;
  assign forward_a_ex = 2'b00;
  assign forward_b_ex = 2'b00;
`endif

  // a taken branch kills the stalled instruction, so flush wins
  assign stall_if = reset & raw_stall & ~pc_src_ex;
  assign stall_id = stall_if;
  assign flush_id = reset & pc_src_ex;
  assign flush_ex = reset & (raw_stall | pc_src_ex);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= {ex_q.valid, ex_q.rd};
      ex_q  <= flush_ex ? '0 : ex_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random scenarios against a
// stage-list reference model of the hazard rules.
module tb_hazard_scoreboard;

  typedef struct {
    bit       w;
    bit       ld;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       pc;
    int       tag;
  } ins_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_id, rs2_id, rd_id;
  logic       reg_write_id;
  logic [1:0] result_src_id;
  logic       pc_src_ex;
  logic       stall_if, stall_id, flush_id, flush_ex;
  logic [1:0] forward_a_ex, forward_b_ex;

  hazard_scoreboard #(.XLEN_REGS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .rd_id        (rd_id),
    .reg_write_id (reg_write_id),
    .result_src_id(result_src_id),
    .pc_src_ex    (pc_src_ex),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .flush_id     (flush_id),
    .flush_ex     (flush_ex),
    .forward_a_ex (forward_a_ex),
    .forward_b_ex (forward_b_ex)
  );

  always #5 clk = ~clk;

  logic [7:0] obs;
  assign obs = {stall_if, stall_id, flush_id, flush_ex,
                forward_a_ex, forward_b_ex};

  int errors = 0;
  int checks = 0;

  // p[0]=EX, p[1]=MEM, p[2]=WB as whole instructions
  ins_t       p[3];
  ins_t       cur;
  logic [7:0] exp_o;
  logic [7:0] obs_log[$];
  logic [7:0] exp_log[$];
  int         stalls;
  logic [1:0] fa_w, fb_w;

  function automatic ins_t mk(int rd, int rs1, int rs2,
                              bit w, bit ld, bit pc, int tag);
    ins_t i;
    i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    i.w = w; i.ld = ld; i.pc = pc; i.tag = tag;
    return i;
  endfunction

  function automatic ins_t bub();
    return mk(0, 0, 0, 0, 0, 0, -1);
  endfunction

  function automatic ins_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bit wr(ins_t i, bit [4:0] r);
    return i.w && i.rd != 0 && i.rd == r;
  endfunction

  function automatic logic [1:0] src(bit [4:0] r);
    if (wr(p[1], r)) return 2'b10;
    if (wr(p[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] model(ins_t i);
    bit dep, st;
    logic [1:0] fa, fb;
    if (!reset) return 8'h00;
`ifdef HAZARD_FORWARD_EN
    dep = p[0].ld && (wr(p[0], i.rs1) || wr(p[0], i.rs2));
    fa = src(p[0].rs1);
    fb = src(p[0].rs2);
`else
    dep = wr(p[0], i.rs1) || wr(p[0], i.rs2)
       || wr(p[1], i.rs1) || wr(p[1], i.rs2);
    fa = 2'b00;
    fb = 2'b00;
`endif
    st = dep && !i.pc;
    return {st, st, i.pc, dep || i.pc, fa, fb};
  endfunction

  task automatic cyc(input ins_t i);
    logic [1:0] r;
    r = 2'($urandom_range(0, 2));
    if (r == 2'b01) r = 2'b11;
    rs1_id        = i.rs1;
    rs2_id        = i.rs2;
    rd_id         = i.rd;
    reg_write_id  = i.w;
    result_src_id = i.ld ? 2'b01 : r;
    pc_src_ex     = i.pc;
    cur           = i;
    exp_o         = model(i);
    @(negedge clk);
  endtask

  task automatic adv();
    if (!reset) begin
      for (int s = 0; s < 3; s++) p[s] = bub();
    end else begin
      p[2] = p[1];
      p[1] = p[0];
      if (exp_o[4]) p[0] = bub();
      else p[0] = cur;
    end
    @(posedge clk);
    #1;
  endtask

  // issues seq in order, holding the ID instruction while stalled
  task automatic play(input ins_t seq[$], input int n, input int watch);
    int k = 0;
    ins_t i;
    obs_log.delete();
    exp_log.delete();
    stalls = 0;
    fa_w = 2'b11;
    fb_w = 2'b11;
    for (int c = 0; c < n; c++) begin
      if (k < seq.size()) i = seq[k];
      else i = nop();
      cyc(i);
      obs_log.push_back(obs);
      exp_log.push_back(exp_o);
      if (p[0].tag == watch) begin
        fa_w = obs[3:2];
        fb_w = obs[1:0];
      end
      if (obs[7]) stalls++;
      if (!exp_o[7]) k++;
      adv();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int s = 0; s < 3; s++) p[s] = bub();
    cyc(mk(5, 5, 5, 1, 1, 1, 0));
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      cyc(mk(5, 5, 5, 1, 1, c, 0));
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset_out: got %b want %b", obs, 8'h00);
      end
      adv();
    end
    reset = 1'b1;
    cyc(mk(6, 5, 5, 1, 0, 0, 0));
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_clear: got %b want %b", obs, 8'h00);
    end
    adv();
  endtask

  task automatic test_fwd_mem();
    ins_t q[$];
    int st_req;
    logic [1:0] f_req;
`ifdef HAZARD_FORWARD_EN
    st_req = 0; f_req = 2'b10;
`else
    st_req = 2; f_req = 2'b00;
`endif
    q = '{mk(5, 1, 2, 1, 0, 0, 1), mk(6, 5, 3, 1, 0, 0, 2)};
    play(q, 7, 2);
    foreach (obs_log[c]) begin
      checks++;
      if (obs_log[c] !== exp_log[c]) begin
        errors++;
        $display("FAIL fwd_mem c%0d: got %b want %b",
                 c, obs_log[c], exp_log[c]);
      end
    end
    checks++;
    if (fa_w !== f_req || stalls != st_req) begin
      errors++;
      $display("FAIL fwd_mem_a: got fa=%b st=%0d want fa=%b st=%0d",
               fa_w, stalls, f_req, st_req);
    end
  endtask

  task automatic test_fwd_wb();
    ins_t q[$];
    int st_req, st2_req;
    logic [1:0] f_req, f2_req;
`ifdef HAZARD_FORWARD_EN
    st_req = 0; f_req = 2'b01; st2_req = 0; f2_req = 2'b10;
`else
    st_req = 1; f_req = 2'b00; st2_req = 4; f2_req = 2'b00;
`endif
    q = '{mk(5, 1, 2, 1, 0, 0, 1), nop(), mk(7, 4, 5, 1, 0, 0, 3)};
    play(q, 7, 3);
    foreach (obs_log[c]) begin
      checks++;
      if (obs_log[c] !== exp_log[c]) begin
        errors++;
        $display("FAIL fwd_wb c%0d: got %b want %b",
                 c, obs_log[c], exp_log[c]);
      end
    end
    checks++;
    if (fb_w !== f_req || stalls != st_req) begin
      errors++;
      $display("FAIL fwd_wb_b: got fb=%b st=%0d want fb=%b st=%0d",
               fb_w, stalls, f_req, st_req);
    end
    q = '{mk(5, 1, 2, 1, 0, 0, 1), mk(5, 5, 3, 1, 0, 0, 2),
          mk(9, 1, 5, 1, 0, 0, 3)};
    play(q, 10, 3);
    foreach (obs_log[c]) begin
      checks++;
      if (obs_log[c] !== exp_log[c]) begin
        errors++;
        $display("FAIL fwd_prio c%0d: got %b want %b",
                 c, obs_log[c], exp_log[c]);
      end
    end
    checks++;
    if (fb_w !== f2_req || stalls != st2_req) begin
      errors++;
      $display("FAIL fwd_prio_b: got fb=%b st=%0d want fb=%b st=%0d",
               fb_w, stalls, f2_req, st2_req);
    end
  endtask

  task automatic test_load_use();
    ins_t q[$];
    int st_req;
    logic [3:0] f_req;
`ifdef HAZARD_FORWARD_EN
    st_req = 1; f_req = 4'b0101;
`else
    st_req = 2; f_req = 4'b0000;
`endif
    q = '{mk(5, 1, 0, 1, 1, 0, 1), mk(6, 5, 5, 1, 0, 0, 2)};
    play(q, 7, 2);
    foreach (obs_log[c]) begin
      checks++;
      if (obs_log[c] !== exp_log[c]) begin
        errors++;
        $display("FAIL load_use c%0d: got %b want %b",
                 c, obs_log[c], exp_log[c]);
      end
    end
    checks++;
    if (obs_log[1] !== 8'b1101_0000) begin
      errors++;
      $display("FAIL load_use_stall: got %b want %b",
               obs_log[1], 8'b1101_0000);
    end
    checks++;
    if ({fa_w, fb_w} !== f_req || stalls != st_req) begin
      errors++;
      $display("FAIL load_use_fwd: got f=%b st=%0d want f=%b st=%0d",
               {fa_w, fb_w}, stalls, f_req, st_req);
    end
  endtask

  task automatic test_branch();
    cyc(mk(5, 1, 0, 1, 1, 0, 1));
    adv();
    cyc(mk(6, 5, 1, 1, 0, 1, 2));
    checks++;
    if (obs[7:4] !== 4'b0011 || obs !== exp_o) begin
      errors++;
      $display("FAIL branch_vs_lw: got %b want %b", obs, exp_o);
    end
    adv();
    cyc(mk(7, 6, 0, 1, 0, 1, 3));
    checks++;
    if (obs !== 8'b0011_0000) begin
      errors++;
      $display("FAIL branch_b2b: got %b want %b", obs, 8'b0011_0000);
    end
    adv();
    cyc(mk(8, 6, 7, 1, 0, 0, 4));
    checks++;
    if (obs !== exp_o || obs[7:4] !== 4'b0000) begin
      errors++;
      $display("FAIL branch_bubble: got %b want %b", obs, exp_o);
    end
    adv();
  endtask

  task automatic test_x0();
    ins_t q[$];
    q = '{mk(0, 1, 2, 1, 0, 0, 1), mk(0, 1, 0, 1, 1, 0, 2),
          mk(3, 0, 0, 1, 0, 0, 3)};
    play(q, 6, 3);
    foreach (obs_log[c]) begin
      checks++;
      if (obs_log[c] !== exp_log[c]) begin
        errors++;
        $display("FAIL x0 c%0d: got %b want %b",
                 c, obs_log[c], exp_log[c]);
      end
    end
    checks++;
    if ({fa_w, fb_w} !== 4'b0000 || stalls != 0) begin
      errors++;
      $display("FAIL x0_fwd: got f=%b st=%0d want f=0000 st=0",
               {fa_w, fb_w}, stalls);
    end
  endtask

  task automatic test_reset_mid_stall();
    cyc(mk(5, 1, 0, 1, 1, 0, 1));
    adv();
    reset = 1'b0;
    cyc(mk(6, 5, 5, 1, 0, 0, 2));
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_stall: got %b want %b", obs, 8'h00);
    end
    adv();
    reset = 1'b1;
    cyc(mk(6, 5, 5, 1, 0, 0, 2));
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL rst_entries: got %b want %b", obs, 8'h00);
    end
    adv();
  endtask

  task automatic test_random();
    ins_t q[$];
    for (int r = 0; r < 10; r++) begin
      q.delete();
      for (int j = 0; j < 30; j++)
        q.push_back(mk($urandom_range(0, 4), $urandom_range(0, 4),
                       $urandom_range(0, 4), $urandom_range(0, 9) < 7,
                       $urandom_range(0, 9) < 3,
                       $urandom_range(0, 9) == 0, 100 + j));
      play(q, 45, -2);
      foreach (obs_log[c]) begin
        checks++;
        if (obs_log[c] !== exp_log[c]) begin
          errors++;
          $display("FAIL random r%0d c%0d: got %b want %b",
                   r, c, obs_log[c], exp_log[c]);
        end
      end
      reset = 1'b0;
      cyc(q[$urandom_range(0, 29)]);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL random_rst r%0d: got %b want %b", r, obs, 8'h00);
      end
      adv();
      reset = 1'b1;
    end
  endtask

  initial begin
    reset         = 1'b0;
    rs1_id        = '0;
    rs2_id        = '0;
    rd_id         = '0;
    reg_write_id  = 1'b0;
    result_src_id = 2'b00;
    pc_src_ex     = 1'b0;
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_load_use();
    test_branch();
    test_x0();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
